// File: rtl/nvm_read_ctrl_if.sv
// Bundles the start/counter/NVM/consumer signals of the NVM read sequencer.
// master = sequencer side, slave = counter, NVM array and consumer side.
interface nvm_read_ctrl_if #(
    parameter int DW = 8
);
    logic          start;
    logic [3:0]    cnt_q;
    logic          cnt_en;
    logic          cnt_clr_n;
    logic          nvm_rd;
    logic [3:0]    nvm_addr;
    logic [DW-1:0] nvm_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport master (
        input  start, cnt_q, nvm_data, out_ready,
        output cnt_en, cnt_clr_n, nvm_rd, nvm_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, cnt_q, nvm_data, out_ready,
        input  cnt_en, cnt_clr_n, nvm_rd, nvm_addr, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/nvm_read_ctrl.sv
// Sequences an external 4-bit address counter through WORDS fixed-latency NVM reads.
// Latency: start at edge E0 -> first out_valid after E0+RD_LAT+1; RD_LAT+2 cycles/word.
// Backpressure: out_valid/out_data hold in PRESENT until out_ready; counter is not stepped.
module nvm_read_ctrl #(
    parameter int WORDS  = 16,
    parameter int RD_LAT = 2,
    parameter int DW     = 8
) (
    input  logic            CLK,
    input  logic            RST,
    nvm_read_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_PRESENT,
        S_ADVANCE,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);
    localparam logic [3:0] LAT       = 4'(RD_LAT);

    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [DW-1:0] out_data_q, out_data_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wait_d  = LAT;
                state_d = S_READ;
            end
            S_READ: begin
                // nvm_data is only guaranteed on the final strobe cycle
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    out_data_d = bus.nvm_data;
                    state_d    = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    state_d = (bus.cnt_q == LAST_ADDR) ? S_DONE : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                wait_d  = LAT;
                state_d = S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs are pure state decodes so nothing combinationally follows out_ready.
    assign bus.cnt_en    = (state_q == S_ADVANCE);
    assign bus.cnt_clr_n = (state_q != S_CLEAR);
    assign bus.nvm_rd    = (state_q == S_READ);
    assign bus.out_valid = (state_q == S_PRESENT);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.nvm_addr  = bus.cnt_q;

    a_ctl_excl: assert property (@(posedge CLK) disable iff (!RST)
        !(bus.cnt_en && !bus.cnt_clr_n));

    a_word_hold: assert property (@(posedge CLK) disable iff (!RST)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_nvm_read_ctrl.sv
// Bench for nvm_read_ctrl: a 16-word and a 4-word instance, each driving its own 4-bit counter.
module tb_nvm_read_ctrl;
    localparam int RD_LAT = 2;
    localparam int DW     = 8;
    localparam int W0     = 16;
    localparam int W1     = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    nvm_read_ctrl_if #(.DW(DW)) if0 ();
    nvm_read_ctrl_if #(.DW(DW)) if1 ();

    logic       st0 = 1'b0, st1 = 1'b0, rdy0 = 1'b0, rdy1 = 1'b0;
    logic [3:0] cnt0, cnt1;

    assign if0.start     = st0;
    assign if0.out_ready = rdy0;
    assign if0.cnt_q     = cnt0;
    assign if0.nvm_data  = {4'h0, if0.nvm_addr} ^ 8'hA5;
    assign if1.start     = st1;
    assign if1.out_ready = rdy1;
    assign if1.cnt_q     = cnt1;
    assign if1.nvm_data  = {4'h0, if1.nvm_addr} ^ 8'hA5;

    // 4-bit counters with async reset, clear over enable
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt0 <= 4'd0;
            cnt1 <= 4'd0;
        end else begin
            if (!if0.cnt_clr_n)  cnt0 <= 4'd0;
            else if (if0.cnt_en) cnt0 <= cnt0 + 4'd1;
            if (!if1.cnt_clr_n)  cnt1 <= 4'd0;
            else if (if1.cnt_en) cnt1 <= cnt1 + 4'd1;
        end
    end

    nvm_read_ctrl #(.WORDS(W0), .RD_LAT(RD_LAT), .DW(DW)) dut16 (.CLK(CLK), .RST(RST), .bus(if0));
    nvm_read_ctrl #(.WORDS(W1), .RD_LAT(RD_LAT), .DW(DW)) dut4  (.CLK(CLK), .RST(RST), .bus(if1));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-timing model: each word appears RD_LAT+1 edges after the start or the previous transfer.
    bit         m_busy[2], m_valid[2], m_done[2], m_clr[2], m_adv[2];
    int         m_word[2], m_wait[2];
    logic [7:0] m_data[2];

    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_done[i] = 1'b0;
                m_clr[i]  = 1'b0; m_adv[i]   = 1'b0;
                m_word[i] = 0;    m_wait[i]  = 0;    m_data[i] = 8'h00;
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if ((i == 0) ? st0 : st1) begin
                    m_busy[i] = 1'b1;
                    m_clr[i]  = 1'b1;
                    m_word[i] = 0;
                    m_wait[i] = RD_LAT + 1;
                end
            end else if (m_valid[i]) begin
                if ((i == 0) ? rdy0 : rdy1) begin
                    m_valid[i] = 1'b0;
                    if (m_word[i] == ((i == 0) ? W0 : W1) - 1) begin
                        m_done[i] = 1'b1;
                    end else begin
                        m_word[i] = m_word[i] + 1;
                        m_adv[i]  = 1'b1;
                        m_wait[i] = RD_LAT + 1;
                    end
                end
            end else begin
                m_clr[i]  = 1'b0;
                m_adv[i]  = 1'b0;
                m_wait[i] = m_wait[i] - 1;
                if (m_wait[i] == 0) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = 8'(m_word[i]) ^ 8'hA5;
                end
            end
        end
    end

    logic [1:0]      d_busy, d_valid, d_done, d_en, d_clrn, d_rd;
    logic [1:0][7:0] d_data;
    logic [1:0][3:0] d_cnt, d_addr;
    assign d_busy  = {if1.busy, if0.busy};
    assign d_valid = {if1.out_valid, if0.out_valid};
    assign d_done  = {if1.done, if0.done};
    assign d_en    = {if1.cnt_en, if0.cnt_en};
    assign d_clrn  = {if1.cnt_clr_n, if0.cnt_clr_n};
    assign d_rd    = {if1.nvm_rd, if0.nvm_rd};
    assign d_data  = {if1.out_data, if0.out_data};
    assign d_cnt   = {cnt1, cnt0};
    assign d_addr  = {if1.nvm_addr, if0.nvm_addr};

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            bit exp_rd;
            exp_rd = m_busy[i] && !m_valid[i] && !m_clr[i] && !m_adv[i] && !m_done[i];
            chk($sformatf("u%0d.busy", i),      32'(d_busy[i]),  32'(m_busy[i]));
            chk($sformatf("u%0d.out_valid", i), 32'(d_valid[i]), 32'(m_valid[i]));
            chk($sformatf("u%0d.done", i),      32'(d_done[i]),  32'(m_done[i]));
            chk($sformatf("u%0d.cnt_en", i),    32'(d_en[i]),    32'(m_adv[i]));
            chk($sformatf("u%0d.cnt_clr_n", i), 32'(d_clrn[i]),  32'(!m_clr[i]));
            chk($sformatf("u%0d.nvm_rd", i),    32'(d_rd[i]),    32'(exp_rd));
            chk($sformatf("u%0d.nvm_addr", i),  32'(d_addr[i]),  32'(d_cnt[i]));
            if (m_valid[i]) chk($sformatf("u%0d.out_data", i), 32'(d_data[i]), 32'(m_data[i]));
            if (m_valid[i] || exp_rd) chk($sformatf("u%0d.cnt_q", i), 32'(d_cnt[i]), 32'(m_word[i]));
        end
    end

    // Transfer log and done-pulse count, sampled at the transfer edge
    logic [3:0] log0_addr[$], log1_addr[$];
    logic [7:0] log0_data[$], log1_data[$];
    int         done0 = 0, done1 = 0;

    always @(posedge CLK) begin
        if (RST) begin
            if (if0.out_valid && rdy0) begin log0_addr.push_back(cnt0); log0_data.push_back(if0.out_data); end
            if (if1.out_valid && rdy1) begin log1_addr.push_back(cnt1); log1_data.push_back(if1.out_data); end
            if (if0.done) done0++;
            if (if1.done) done1++;
        end
    end

    task automatic pulse_start(input int i, output int c0);
        @(negedge CLK); #1;
        if (i == 0) st0 = 1'b1; else st1 = 1'b1;
        @(posedge CLK); #1;
        c0 = cyc;
        if (i == 0) st0 = 1'b0; else st1 = 1'b0;
    endtask

    initial begin
        int n, c0, fv, dc, d;

        // Reset state
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy",      32'(if0.busy),      32'd0);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data",  32'(if0.out_data),  32'd0);
        chk("rst_done",      32'(if0.done),      32'd0);
        chk("rst_nvm_rd",    32'(if0.nvm_rd),    32'd0);
        chk("rst_cnt_en",    32'(if0.cnt_en),    32'd0);
        chk("rst_cnt_clr_n", 32'(if0.cnt_clr_n), 32'd1);
        chk("rst_cnt_q",     32'(cnt0),          32'd0);
        chk("rst_busy4",     32'(if1.busy),      32'd0);
        RST  = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;

        // Full 16-word burst with a start pulse during word 2
        pulse_start(0, c0);
        fv = -1; dc = -1; n = 0;
        do begin
            @(negedge CLK); n++;
            if (fv < 0 && if0.out_valid) fv = cyc - c0;
            if (if0.done) dc = cyc - c0;
            if (n == 10) begin #1; st0 = 1'b1; end
            else if (n == 11) begin #1; st0 = 1'b0; end
        end while (dc < 0 && n < 150);
        chk("b16_timeout",     32'(n < 150),          32'd1);
        chk("b16_first_valid", 32'(fv),               32'd3);
        chk("b16_done_at",     32'(dc),               32'd64);
        chk("b16_xfers",       32'(log0_addr.size()), 32'd16);
        for (int k = 0; k < log0_addr.size() && k < 16; k++) begin
            chk($sformatf("b16_addr%0d", k), 32'(log0_addr[k]), 32'(k));
            chk($sformatf("b16_data%0d", k), 32'(log0_data[k]), 32'(8'(k) ^ 8'hA5));
        end
        chk("b16_data7_lit", 32'(log0_data[7]), 32'h0A2);
        repeat (3) @(negedge CLK);
        chk("b16_done_once", 32'(done0),    32'd1);
        chk("b16_idle",      32'(if0.busy), 32'd0);

        // Backpressure on word 3
        log0_addr.delete(); log0_data.delete();
        pulse_start(0, c0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!(if0.out_valid && cnt0 == 4'd3) && n < 100);
        chk("bp_timeout", 32'(n < 100), 32'd1);
        #1 rdy0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("bp_valid",  32'(if0.out_valid), 32'd1);
            chk("bp_data",   32'(if0.out_data),  32'h0A6);
            chk("bp_cnt_en", 32'(if0.cnt_en),    32'd0);
            chk("bp_cnt_q",  32'(cnt0),          32'd3);
        end
        #1 rdy0 = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!if0.done && n < 150);
        chk("bp_done_timeout", 32'(n < 150),          32'd1);
        chk("bp_xfers",        32'(log0_addr.size()), 32'd16);
        chk("bp_word3",        32'(log0_data[3]),     32'h0A6);
        chk("bp_addr4",        32'(log0_addr[4]),     32'd4);
        chk("bp_word4",        32'(log0_data[4]),     32'h0A1);
        repeat (2) @(negedge CLK);

        // Short 4-word burst, then a burst with start held across DONE->IDLE
        pulse_start(1, c0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!if1.done && n < 60);
        chk("b4_timeout", 32'(n < 60), 32'd1);
        repeat (3) @(negedge CLK);
        chk("b4_done_once", 32'(done1),            32'd1);
        chk("b4_xfers",     32'(log1_addr.size()), 32'd4);
        chk("b4_cnt_end",   32'(cnt1),             32'd3);
        #1 st1 = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!if1.done && n < 60);
        chk("b4h_timeout", 32'(n < 60), 32'd1);
        @(posedge CLK); @(posedge CLK); #1 st1 = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (!if1.done && n < 60);
        chk("b4r_timeout", 32'(n < 60), 32'd1);
        repeat (3) @(negedge CLK);
        chk("b4_done_total", 32'(done1),            32'd3);
        chk("b4_xfers_tot",  32'(log1_addr.size()), 32'd12);
        for (int k = 0; k < log1_addr.size() && k < 12; k++) begin
            chk($sformatf("b4_addr%0d", k), 32'(log1_addr[k]), 32'(k % 4));
        end
        chk("b4_idle", 32'(if1.busy), 32'd0);

        // Reset during the read of word 5
        d = done0;
        pulse_start(0, c0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!(if0.nvm_rd && cnt0 == 4'd5) && n < 100);
        chk("mr_timeout", 32'(n < 100), 32'd1);
        #1 RST = 1'b0;
        #1;
        chk("mr_busy",   32'(if0.busy),      32'd0);
        chk("mr_valid",  32'(if0.out_valid), 32'd0);
        chk("mr_nvm_rd", 32'(if0.nvm_rd),    32'd0);
        repeat (2) @(negedge CLK);
        chk("mr_no_done", 32'(done0), 32'(d));
        #1 RST = 1'b1;
        log0_addr.delete(); log0_data.delete();
        pulse_start(0, c0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!if0.done && n < 150);
        chk("mr2_timeout",  32'(n < 150),          32'd1);
        chk("mr2_xfers",    32'(log0_addr.size()), 32'd16);
        chk("mr2_addr0",    32'(log0_addr[0]),     32'd0);
        chk("mr2_data0",    32'(log0_data[0]),     32'h0A5);
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
